// File: rtl/reg_read_arbiter.sv
// Round-robin arbiter sharing the register-file read port among NREQ requesters.
// Two-stage pipeline (select, then read), with forwarding of a same-cycle CDB write.
module reg_read_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_reg,
    output logic [NREQ-1:0]   gnt,
    output logic [3:0]        regnumber,
    input  logic [15:0]       regout,
    input  logic              wr_en,
    input  logic [3:0]        wr_reg,
    input  logic [15:0]       wr_data,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_data,
    output logic              rsp_err
);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] cand;
    logic           win_found;
    logic           s1_valid;
    logic [IDW-1:0] s1_id;
    logic           reg_ok;
    logic           fwd_hit;

    // Search starts just after the last winner; the first pending request wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        gnt       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        if (win_found && !reset) begin
            gnt[win_idx] = 1'b1;
        end
    end

    assign reg_ok  = (regnumber >= 4'd1) && (regnumber <= 4'd6);
    assign fwd_hit = wr_en && (wr_reg == regnumber);

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr    <= IDW'(NREQ - 1);
            regnumber <= 4'b0000;
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 16'h0000;
            rsp_err   <= 1'b0;
        end else begin
            s1_valid <= win_found;
            if (win_found) begin
                rr_ptr    <= win_idx;
                s1_id     <= win_idx;
                regnumber <= req_reg[{win_idx, 2'b00} +: 4];
            end
            // Response fields only change with a new response and hold otherwise.
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_id <= s1_id;
                if (!reg_ok) begin
                    rsp_err  <= 1'b1;
                    rsp_data <= 16'h0000;
                end else if (fwd_hit) begin
                    rsp_err  <= 1'b0;
                    rsp_data <= wr_data;
                end else begin
                    rsp_err  <= 1'b0;
                    rsp_data <= regout;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Bench for reg_read_arbiter: a cycle table of inputs and expected outputs,
// plus hand-written reset sequences and a small register-file model.
module tb_reg_read_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_reg;
    logic [3:0]  gnt;
    logic [3:0]  regnumber;
    logic [15:0] regout;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;

    int n_cmp;
    int n_fail;

    reg_read_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clock(clock), .reset(reset), .req(req), .req_reg(req_reg), .gnt(gnt),
        .regnumber(regnumber), .regout(regout), .wr_en(wr_en), .wr_reg(wr_reg),
        .wr_data(wr_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model: reset loads known contents, CDB writes land at the edge.
    logic [15:0] rf [16];
    function automatic logic [15:0] init_val(input int i);
        if (i == 3) return 16'h00A5;
        if (i == 5) return 16'h1111;
        return 16'hC000 | 16'(i);
    endfunction
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
        end else if (wr_en) begin
            rf[wr_reg] <= wr_data;
        end
    end
    assign regout = rf[regnumber];

    typedef struct {
        logic [3:0]  req;
        logic [15:0] req_reg;
        logic        wr_en;
        logic [3:0]  wr_reg;
        logic [15:0] wr_data;
        logic [3:0]  gnt;
        logic [3:0]  rn;
        logic        rv;
        logic [1:0]  id;
        logic [15:0] data;
        logic        err;
    } vec_t;

    vec_t tbl [34];

    function automatic vec_t mk(input logic [3:0] r, input logic [15:0] rr, input logic we,
                                input logic [3:0] wreg, input logic [15:0] wd, input logic [3:0] g,
                                input logic [3:0] rn, input logic rv, input logic [1:0] id,
                                input logic [15:0] d, input logic e);
        vec_t v;
        v.req = r; v.req_reg = rr; v.wr_en = we; v.wr_reg = wreg; v.wr_data = wd;
        v.gnt = g; v.rn = rn; v.rv = rv; v.id = id; v.data = d; v.err = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    logic [1:0]  hold_id;
    logic [15:0] hold_data;
    logic        hold_err;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1; req = 4'b1111; req_reg = 16'h4321;
        wr_en = 1'b0; wr_reg = 4'd0; wr_data = 16'h0000;

        // cycle columns: req, req_reg, wr_en, wr_reg, wr_data | gnt, regnumber, rsp_valid, id, data, err
        tbl[0]  = mk(4'hF, 16'h4321, 0, 0, 0,       4'h1, 4'd0, 0, 0, 0,       0);
        tbl[1]  = mk(4'hF, 16'h4321, 0, 0, 0,       4'h2, 4'd1, 0, 0, 0,       0);
        tbl[2]  = mk(4'hF, 16'h4321, 0, 0, 0,       4'h4, 4'd2, 1, 0, 16'hC001, 0);
        tbl[3]  = mk(4'hF, 16'h4321, 0, 0, 0,       4'h8, 4'd3, 1, 1, 16'hC002, 0);
        tbl[4]  = mk(4'hF, 16'h4321, 0, 0, 0,       4'h1, 4'd4, 1, 2, 16'h00A5, 0);
        tbl[5]  = mk(4'hF, 16'h4321, 0, 0, 0,       4'h2, 4'd1, 1, 3, 16'hC004, 0);
        tbl[6]  = mk(4'hF, 16'h4321, 0, 0, 0,       4'h4, 4'd2, 1, 0, 16'hC001, 0);
        tbl[7]  = mk(4'hF, 16'h4321, 0, 0, 0,       4'h8, 4'd3, 1, 1, 16'hC002, 0);
        tbl[8]  = mk(4'h0, 16'h4321, 0, 0, 0,       4'h0, 4'd4, 1, 2, 16'h00A5, 0);
        tbl[9]  = mk(4'h0, 16'h4321, 0, 0, 0,       4'h0, 4'd4, 1, 3, 16'hC004, 0);
        tbl[10] = mk(4'h0, 16'h4321, 0, 0, 0,       4'h0, 4'd4, 0, 0, 0,       0);
        tbl[11] = mk(4'h4, 16'h4321, 0, 0, 0,       4'h4, 4'd4, 0, 0, 0,       0);
        tbl[12] = mk(4'h0, 16'h4321, 0, 0, 0,       4'h0, 4'd3, 0, 0, 0,       0);
        tbl[13] = mk(4'h0, 16'h4321, 0, 0, 0,       4'h0, 4'd3, 1, 2, 16'h00A5, 0);
        tbl[14] = mk(4'h2, 16'h4351, 0, 0, 0,       4'h2, 4'd3, 0, 0, 0,       0);
        tbl[15] = mk(4'h0, 16'h4351, 1, 4, 16'hBEEF, 4'h0, 4'd5, 0, 0, 0,      0);
        tbl[16] = mk(4'h0, 16'h4351, 0, 0, 0,       4'h0, 4'd5, 1, 1, 16'h1111, 0);
        tbl[17] = mk(4'h2, 16'h4351, 0, 0, 0,       4'h2, 4'd5, 0, 0, 0,       0);
        tbl[18] = mk(4'h0, 16'h4351, 1, 5, 16'hBEEF, 4'h0, 4'd5, 0, 0, 0,      0);
        tbl[19] = mk(4'h0, 16'h4351, 0, 0, 0,       4'h0, 4'd5, 1, 1, 16'hBEEF, 0);
        tbl[20] = mk(4'h8, 16'h6351, 1, 6, 16'h1234, 4'h8, 4'd5, 0, 0, 0,      0);
        tbl[21] = mk(4'h0, 16'h6351, 0, 0, 0,       4'h0, 4'd6, 0, 0, 0,       0);
        tbl[22] = mk(4'h0, 16'h6351, 0, 0, 0,       4'h0, 4'd6, 1, 3, 16'h1234, 0);
        tbl[23] = mk(4'h1, 16'h6350, 0, 0, 0,       4'h1, 4'd6, 0, 0, 0,       0);
        tbl[24] = mk(4'h1, 16'h6357, 0, 0, 0,       4'h1, 4'd0, 0, 0, 0,       0);
        tbl[25] = mk(4'h0, 16'h6357, 0, 0, 0,       4'h0, 4'd7, 1, 0, 16'h0000, 1);
        tbl[26] = mk(4'h0, 16'h6357, 0, 0, 0,       4'h0, 4'd7, 1, 0, 16'h0000, 1);
        tbl[27] = mk(4'h0, 16'h6357, 0, 0, 0,       4'h0, 4'd7, 0, 0, 0,       0);
        tbl[28] = mk(4'h3, 16'h6321, 0, 0, 0,       4'h2, 4'd7, 0, 0, 0,       0);
        tbl[29] = mk(4'h3, 16'h6321, 0, 0, 0,       4'h1, 4'd2, 0, 0, 0,       0);
        tbl[30] = mk(4'h2, 16'h6321, 0, 0, 0,       4'h2, 4'd1, 1, 1, 16'hC002, 0);
        tbl[31] = mk(4'h0, 16'h6321, 0, 0, 0,       4'h0, 4'd2, 1, 0, 16'hC001, 0);
        tbl[32] = mk(4'h0, 16'h6321, 0, 0, 0,       4'h0, 4'd2, 1, 1, 16'hC002, 0);
        tbl[33] = mk(4'h0, 16'h6321, 0, 0, 0,       4'h0, 4'd2, 0, 0, 0,       0);

        // Reset held two cycles with every request active.
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge clock);
            check($sformatf("reset%0d_gnt", c), 32'(gnt), 32'h0);
            check($sformatf("reset%0d_regnumber", c), 32'(regnumber), 32'h0);
            check($sformatf("reset%0d_rsp_valid", c), 32'(rsp_valid), 32'h0);
        end
        next_cycle();
        reset = 1'b0;

        hold_id = 2'd0; hold_data = 16'h0000; hold_err = 1'b0;
        for (int i = 0; i < 34; i++) begin
            req = tbl[i].req; req_reg = tbl[i].req_reg;
            wr_en = tbl[i].wr_en; wr_reg = tbl[i].wr_reg; wr_data = tbl[i].wr_data;
            if (tbl[i].rv) begin
                hold_id = tbl[i].id; hold_data = tbl[i].data; hold_err = tbl[i].err;
            end
            @(negedge clock);
            check($sformatf("c%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            check($sformatf("c%0d_regnumber", i), 32'(regnumber), 32'(tbl[i].rn));
            check($sformatf("c%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rv));
            check($sformatf("c%0d_rsp_id", i), 32'(rsp_id), 32'(hold_id));
            check($sformatf("c%0d_rsp_data", i), 32'(rsp_data), 32'(hold_data));
            check($sformatf("c%0d_rsp_err", i), 32'(rsp_err), 32'(hold_err));
            next_cycle();
        end

        // Reset while a grant is in flight: nothing may come out of the pipe.
        req = 4'b0001; req_reg = 16'h6321; wr_en = 1'b0;
        @(negedge clock);
        check("mid_grant_gnt", 32'(gnt), 32'h1);
        next_cycle();
        reset = 1'b1; req = 4'b0000;
        @(negedge clock);
        check("mid_reset_gnt", 32'(gnt), 32'h0);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check("mid_c2_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_c2_rsp_data", 32'(rsp_data), 32'h0);
        check("mid_c2_regnumber", 32'(regnumber), 32'h0);
        next_cycle();
        req = 4'b0011;
        @(negedge clock);
        check("mid_c3_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_c3_gnt_after_ptr_reset", 32'(gnt), 32'h1);
        next_cycle();
        req = 4'b0000;
        @(negedge clock);
        check("mid_c4_rsp_valid", 32'(rsp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
